id_ex_stage: RTL and testbench

//  ID/EX pipeline stage feeding the ALU: registers decoded ops, resolves operand forwarding, drives ctl/data_1/data_2.
//  2-entry skid buffer (main + skid) with valid/ready on both sides; in_ready comes straight from a flop.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: a two-entry (main + skid) buffer of decoded ALU ops.
// Operands are forwarded when an op is captured, refreshed from the forward
// buses on every cycle it is held, and forwarded once more on the way out.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTL_W-1:0]  in_ctl,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic              in_wr,
   input  logic              exm_wr,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_data,
   input  logic              mwb_wr,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic [DATA_W-1:0] mwb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTL_W-1:0]  ctl,
   output logic [DATA_W-1:0] data_1,
   output logic [DATA_W-1:0] data_2,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wr
);

   typedef struct packed {
      logic [CTL_W-1:0]  ctl;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] rs_val;
      logic [DATA_W-1:0] rt_val;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
      logic              wr;
   } entry_t;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_entry_s;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   in_xfer_s, out_xfer_s;

   // Register 0 is hardwired, so it is never forwarded; EX/MEM is newer than MEM/WB.
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] idx,
                                             input logic [DATA_W-1:0] val);
      logic [DATA_W-1:0] r;
      if (idx == {REG_AW{1'b0}}) begin
         r = val;
      end else if (exm_wr && (exm_rd == idx)) begin
         r = exm_data;
      end else if (mwb_wr && (mwb_rd == idx)) begin
         r = mwb_data;
      end else begin
         r = val;
      end
      return r;
   endfunction

   // A held entry re-forwards its stored operands so it cannot miss a writeback.
   function automatic entry_t refresh(input entry_t e);
      entry_t r;
      r        = e;
      r.rs_val = fwd(e.rs, e.rs_val);
      r.rt_val = fwd(e.rt, e.rt_val);
      return r;
   endfunction

   // Build the incoming entry with operands forwarded at capture time.
   always_comb begin
      in_entry_s         = '0;
      in_entry_s.ctl     = in_ctl;
      in_entry_s.rs      = in_rs;
      in_entry_s.rt      = in_rt;
      in_entry_s.rd      = in_rd;
      in_entry_s.rs_val  = fwd(in_rs, in_rs_val);
      in_entry_s.rt_val  = fwd(in_rt, in_rt_val);
      in_entry_s.imm     = in_imm;
      in_entry_s.use_imm = in_use_imm;
      in_entry_s.wr      = in_wr;
   end

   // Next-state for the main/skid buffer: EMPTY(00), ONE(10), FULL(11); flush drops all.
   always_comb begin
      in_xfer_s    = in_valid & in_ready_q;
      out_xfer_s   = main_valid_q & out_ready;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (main_valid_q) begin
         main_d = refresh(main_q);
      end else begin
         main_d = main_q;
      end
      if (skid_valid_q) begin
         skid_d = refresh(skid_q);
      end else begin
         skid_d = skid_q;
      end

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (in_xfer_s) begin
                  main_d       = in_entry_s;
                  main_valid_d = 1'b1;
               end else begin
                  main_valid_d = 1'b0;
               end
            end
            2'b10: begin
               if (in_xfer_s && out_xfer_s) begin
                  main_d = in_entry_s;
               end else if (in_xfer_s) begin
                  skid_d       = in_entry_s;
                  skid_valid_d = 1'b1;
               end else if (out_xfer_s) begin
                  main_valid_d = 1'b0;
               end else begin
                  main_valid_d = 1'b1;
               end
            end
            2'b11: begin
               if (out_xfer_s) begin
                  main_d       = refresh(skid_q);
                  skid_valid_d = 1'b0;
               end else begin
                  skid_valid_d = 1'b1;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers; reset clears both entries and their payloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // ALU-facing outputs from the main entry, with a last forwarding pass.
   always_comb begin
      in_ready  = in_ready_q;
      out_valid = main_valid_q;
      ctl       = main_q.ctl;
      out_rd    = main_q.rd;
      out_wr    = main_q.wr & main_valid_q;
      data_1    = fwd(main_q.rs, main_q.rs_val);
      if (main_q.use_imm) begin
         data_2 = main_q.imm;
      end else begin
         data_2 = fwd(main_q.rt, main_q.rt_val);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an expected-output scoreboard queue.
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CTL_W  = 4;
   localparam logic [CTL_W-1:0] OP_ADD = 4'd2;
   localparam logic [CTL_W-1:0] OP_SUB = 4'd6;
   localparam logic [CTL_W-1:0] OP_OR  = 4'd1;
   localparam logic [CTL_W-1:0] OP_AND = 4'd0;

   logic              clk = 1'b0;
   logic              rst = 1'b0, flush = 1'b0;
   logic              in_valid = 1'b0, in_ready;
   logic [CTL_W-1:0]  in_ctl = '0;
   logic [REG_AW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
   logic [DATA_W-1:0] in_rs_val = '0, in_rt_val = '0, in_imm = '0;
   logic              in_use_imm = 1'b0, in_wr = 1'b0;
   logic              exm_wr = 1'b0, mwb_wr = 1'b0;
   logic [REG_AW-1:0] exm_rd = '0, mwb_rd = '0;
   logic [DATA_W-1:0] exm_data = '0, mwb_data = '0;
   logic              out_valid, out_ready = 1'b0;
   logic [CTL_W-1:0]  ctl;
   logic [DATA_W-1:0] data_1, data_2;
   logic [REG_AW-1:0] out_rd;
   logic              out_wr;

   typedef struct packed {
      logic [CTL_W-1:0]  ctl;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      logic [REG_AW-1:0] rd;
      logic              wr;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   int   tests = 0, fails = 0;
   int   cyc = 0, out_cnt = 0, first_out = -1, last_out = -1;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTL_W(CTL_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctl(in_ctl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_wr(in_wr),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .ctl(ctl), .data_1(data_1), .data_2(data_2),
      .out_rd(out_rd), .out_wr(out_wr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive an op and remember what it should look like at the output.
   task automatic send(input logic [CTL_W-1:0] c, input logic [REG_AW-1:0] rs,
                       input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                       input logic [DATA_W-1:0] rsv, input logic [DATA_W-1:0] rtv,
                       input logic [DATA_W-1:0] imm, input logic ui, input logic wr,
                       input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
      in_valid = 1'b1; in_ctl = c; in_rs = rs; in_rt = rt; in_rd = rd;
      in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_use_imm = ui; in_wr = wr;
      pend = '{ctl: c, d1: e1, d2: e2, rd: rd, wr: wr};
   endtask

   // One clock: check/pop outputs and record accepts at negedge, then step past posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         out_cnt++;
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_out", {91'd0, out_valid}, 96'd0);
         end else begin
            e = sb.pop_front();
            chk("out_payload", {22'd0, ctl, data_1, data_2, out_rd, out_wr}, {22'd0, e});
         end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready && !flush && !rst) sb.push_back(pend);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      // 1 reset
      rst = 1'b1;
      cycle(); cycle();
      chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
      chk("rst_data_1", {64'd0, data_1}, 96'd0);
      chk("rst_data_2", {64'd0, data_2}, 96'd0);
      chk("rst_out_wr", {95'd0, out_wr}, 96'd0);
      rst = 1'b0;
      cycle();

      // 2 streaming at full rate
      out_ready = 1'b1; out_cnt = 0; first_out = -1;
      send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 32'd5, 32'd7);
      cycle();
      chk("add_valid", {95'd0, out_valid}, 96'd1);
      chk("add_ctl", {92'd0, ctl}, {92'd0, OP_ADD});
      chk("add_d1", {64'd0, data_1}, 96'd5);
      chk("add_d2", {64'd0, data_2}, 96'd7);
      send(OP_SUB, 5'd5, 5'd6, 5'd4, 32'd100, 32'd30, 32'd0, 1'b0, 1'b1, 32'd100, 32'd30);
      cycle();
      chk("stream_in_ready", {95'd0, in_ready}, 96'd1);
      send(OP_OR, 5'd8, 5'd0, 5'd7, 32'hF0, 32'h99, 32'h0F, 1'b1, 1'b1, 32'hF0, 32'h0F);
      cycle();
      send(OP_AND, 5'd10, 5'd11, 5'd9, 32'h1234, 32'h00FF, 32'd0, 1'b0, 1'b0, 32'h1234, 32'h00FF);
      cycle();
      chk("stream_in_ready2", {95'd0, in_ready}, 96'd1);
      in_valid = 1'b0;
      cycle();
      chk("stream_count", 96'(out_cnt), 96'd4);
      chk("stream_span", 96'(last_out - first_out), 96'd3);
      chk("stream_drained", {95'd0, out_valid}, 96'd0);

      // 3 backpressure into FULL, then drain in order
      out_ready = 1'b0;
      send(OP_ADD, 5'd12, 5'd13, 5'd14, 32'hA1, 32'hA2, 32'd0, 1'b0, 1'b1, 32'hA1, 32'hA2);
      cycle();
      send(OP_SUB, 5'd15, 5'd16, 5'd17, 32'hB1, 32'hB2, 32'd0, 1'b0, 1'b1, 32'hB1, 32'hB2);
      cycle();
      chk("full_in_ready", {95'd0, in_ready}, 96'd0);
      chk("full_main_is_a", {64'd0, data_1}, 96'hA1);
      in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      chk("after_a_in_ready", {95'd0, in_ready}, 96'd1);
      chk("after_a_main_is_b", {64'd0, data_1}, 96'hB1);
      cycle();
      chk("bp_drained", {95'd0, out_valid}, 96'd0);

      // 4 forwarding priority
      out_ready = 1'b0;
      exm_wr = 1'b1; exm_rd = 5'd4; exm_data = 32'hAAAA;
      mwb_wr = 1'b1; mwb_rd = 5'd4; mwb_data = 32'hBBBB;
      send(OP_ADD, 5'd4, 5'd2, 5'd1, 32'h1111, 32'h22, 32'd0, 1'b0, 1'b1, 32'hBBBB, 32'h22);
      cycle();
      chk("fwd_exm_wins", {64'd0, data_1}, 96'hAAAA);
      in_valid = 1'b0; exm_wr = 1'b0;
      #1;
      chk("fwd_mwb", {64'd0, data_1}, 96'hBBBB);
      cycle();
      mwb_wr = 1'b0;
      #1;
      chk("fwd_stored", {64'd0, data_1}, 96'hBBBB);
      out_ready = 1'b1;
      cycle();
      exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'hDEAD;
      send(OP_OR, 5'd0, 5'd3, 5'd2, 32'h1234, 32'h5, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h5);
      cycle();
      chk("fwd_r0_regfile", {64'd0, data_1}, 96'h1234);
      in_valid = 1'b0;
      cycle();
      exm_wr = 1'b0;

      // 5 held entry refreshed by a one-cycle writeback
      out_ready = 1'b0;
      send(OP_ADD, 5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 32'h55, 32'd2);
      cycle();
      in_valid = 1'b0;
      mwb_wr = 1'b1; mwb_rd = 5'd6; mwb_data = 32'h55;
      cycle();
      mwb_wr = 1'b0;
      #1;
      chk("stale_refreshed", {64'd0, data_1}, 96'h55);
      out_ready = 1'b1;
      cycle();

      // 6 flush from FULL with a new op offered
      out_ready = 1'b0;
      send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h11, 32'h12, 32'd0, 1'b0, 1'b1, 32'h11, 32'h12);
      cycle();
      send(OP_SUB, 5'd4, 5'd5, 5'd6, 32'h21, 32'h22, 32'd0, 1'b0, 1'b1, 32'h21, 32'h22);
      cycle();
      chk("pre_flush_full", {95'd0, in_ready}, 96'd0);
      send(OP_OR, 5'd7, 5'd8, 5'd9, 32'h31, 32'h32, 32'd0, 1'b0, 1'b1, 32'h31, 32'h32);
      flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", {95'd0, out_valid}, 96'd0);
      chk("flush_in_ready", {95'd0, in_ready}, 96'd1);
      chk("flush_out_wr", {95'd0, out_wr}, 96'd0);
      out_ready = 1'b1; out_cnt = 0;
      cycle(); cycle(); cycle();
      chk("flush_no_late_out", 96'(out_cnt), 96'd0);
      chk("sb_empty", 96'(sb.size()), 96'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
